// File: rtl/audio_bit_lr_clock_gen.sv
// Audio BCLK/LRCK generator with registered single-cycle edge strobes.
// Define AUDIO_CLK_SLAVE_EN to follow codec-supplied clocks instead of dividing clk.
module audio_bit_lr_clock_gen #(
    parameter int BCLK_HALF_PERIOD = 8,
    parameter int BITS_PER_CHANNEL = 32,
    parameter int IDX_W            = $clog2(BITS_PER_CHANNEL)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             bclk,
    output logic             lrck,
    output logic             bit_clk_rising_edge,
    output logic             bit_clk_falling_edge,
    output logic             left_right_clk_rising_edge,
    output logic             left_right_clk_falling_edge,
    output logic [IDX_W-1:0] bit_index
`ifdef AUDIO_CLK_SLAVE_EN
    ,
    input  logic             bclk_in,
    input  logic             lrck_in
`endif
);

`ifdef AUDIO_CLK_SLAVE_EN

    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;
    logic [1:0] prev_reg;
    logic       bclk_fall;
    logic       lr_change;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_reg <= 2'b00;
            sync2_reg <= 2'b00;
        end else begin
            sync1_reg <= {lrck_in, bclk_in};
            sync2_reg <= sync1_reg;
        end
    end

    assign bclk      = sync2_reg[0];
    assign lrck      = sync2_reg[1];
    assign bclk_fall = prev_reg[0] & ~sync2_reg[0];
    assign lr_change = prev_reg[1] ^ sync2_reg[1];

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            prev_reg                    <= 2'b00;
            bit_clk_rising_edge         <= 1'b0;
            bit_clk_falling_edge        <= 1'b0;
            left_right_clk_rising_edge  <= 1'b0;
            left_right_clk_falling_edge <= 1'b0;
            bit_index                   <= '0;
        end else begin
            prev_reg                    <= sync2_reg;
            bit_clk_rising_edge         <= sync2_reg[0] & ~prev_reg[0];
            bit_clk_falling_edge        <= bclk_fall;
            left_right_clk_rising_edge  <= sync2_reg[1] & ~prev_reg[1];
            left_right_clk_falling_edge <= prev_reg[1] & ~sync2_reg[1];
            // A frame boundary restarts the count even when it lands on a BCLK fall.
            if (lr_change)
                bit_index <= '0;
            else if (bclk_fall)
                bit_index <= bit_index + IDX_W'(1);
        end
    end

`else

    localparam int DIV_W = $clog2(BCLK_HALF_PERIOD);

    logic [DIV_W-1:0] div_cnt_reg;

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            div_cnt_reg                 <= '0;
            bclk                        <= 1'b0;
            lrck                        <= 1'b0;
            bit_clk_rising_edge         <= 1'b0;
            bit_clk_falling_edge        <= 1'b0;
            left_right_clk_rising_edge  <= 1'b0;
            left_right_clk_falling_edge <= 1'b0;
            bit_index                   <= '0;
        end else begin
            bit_clk_rising_edge         <= 1'b0;
            bit_clk_falling_edge        <= 1'b0;
            left_right_clk_rising_edge  <= 1'b0;
            left_right_clk_falling_edge <= 1'b0;
            if (div_cnt_reg == DIV_W'(BCLK_HALF_PERIOD - 1)) begin
                div_cnt_reg <= '0;
                bclk        <= ~bclk;
                if (!bclk) begin
                    bit_clk_rising_edge <= 1'b1;
                end else begin
                    bit_clk_falling_edge <= 1'b1;
                    // LRCK only ever moves on a BCLK fall so frames start left-justified.
                    if (bit_index == IDX_W'(BITS_PER_CHANNEL - 1)) begin
                        bit_index <= '0;
                        lrck      <= ~lrck;
                        if (!lrck)
                            left_right_clk_rising_edge <= 1'b1;
                        else
                            left_right_clk_falling_edge <= 1'b1;
                    end else begin
                        bit_index <= bit_index + IDX_W'(1);
                    end
                end
            end else begin
                div_cnt_reg <= div_cnt_reg + DIV_W'(1);
            end
        end
    end

`endif

endmodule

// File: tb/tb_audio_bit_lr_clock_gen.sv
// Scoreboard bench: two generators (default and minimum parameters) share stimulus;
// expected outputs come from edge-count arithmetic.
module tb_audio_bit_lr_clock_gen;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;

    logic       bclk_a, lrck_a, br_a, bf_a, lrr_a, lrf_a;
    logic [4:0] idx_a;
    logic       bclk_b, lrck_b, br_b, bf_b, lrr_b, lrf_b;
    logic [0:0] idx_b;

    always #5 clk = ~clk;

    audio_bit_lr_clock_gen #(.BCLK_HALF_PERIOD(8), .BITS_PER_CHANNEL(32)) dut_a (
        .clk(clk), .reset(reset), .enable(enable),
        .bclk(bclk_a), .lrck(lrck_a),
        .bit_clk_rising_edge(br_a), .bit_clk_falling_edge(bf_a),
        .left_right_clk_rising_edge(lrr_a), .left_right_clk_falling_edge(lrf_a),
        .bit_index(idx_a)
`ifdef AUDIO_CLK_SLAVE_EN
        , .bclk_in(1'b0), .lrck_in(1'b0)
`endif
    );

    audio_bit_lr_clock_gen #(.BCLK_HALF_PERIOD(2), .BITS_PER_CHANNEL(2)) dut_b (
        .clk(clk), .reset(reset), .enable(enable),
        .bclk(bclk_b), .lrck(lrck_b),
        .bit_clk_rising_edge(br_b), .bit_clk_falling_edge(bf_b),
        .left_right_clk_rising_edge(lrr_b), .left_right_clk_falling_edge(lrf_b),
        .bit_index(idx_b)
`ifdef AUDIO_CLK_SLAVE_EN
        , .bclk_in(1'b0), .lrck_in(1'b0)
`endif
    );

    typedef struct packed {
        int           t;
        logic [15:0]  a;
        logic [15:0]  b;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   t     = 0;   // clk edges since the generator last started from cleared state
    bit   started = 0;

    // Expected outputs t edges after restart, from the timing rules alone.
    function automatic logic [15:0] model(input int tt, input int h, input int b);
        int  frame_half;
        logic bc, lr, brs, bfs, lrrs, lrfs;
        logic [9:0] idx;
        frame_half = 2 * h * b;
        bc   = ((tt / h) % 2) == 1;
        brs  = (tt > 0) && (tt % h == 0) && ((tt / h) % 2 == 1);
        bfs  = (tt > 0) && (tt % h == 0) && ((tt / h) % 2 == 0);
        lr   = ((tt / frame_half) % 2) == 1;
        lrrs = (tt > 0) && (tt % frame_half == 0) && ((tt / frame_half) % 2 == 1);
        lrfs = (tt > 0) && (tt % frame_half == 0) && ((tt / frame_half) % 2 == 0);
        idx  = 10'((tt / (2 * h)) % b);
        return {bc, lr, brs, bfs, lrrs, lrfs, idx};
    endfunction

    task automatic step(input logic r, input logic e);
        exp_t x;
        @(negedge clk);
        reset  = r;
        enable = e;
        if (r || !e) t = 0;
        else         t = t + 1;
        x.t = t;
        x.a = model(t, 8, 32);
        x.b = model(t, 2, 2);
        exp_q.push_back(x);
        started = 1;
    endtask

    // Monitor: every clk edge presents a new output set.
    initial begin
        exp_t x;
        logic [15:0] got_a, got_b;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                x = exp_q.pop_front();
                got_a = {bclk_a, lrck_a, br_a, bf_a, lrr_a, lrf_a, 10'(idx_a)};
                got_b = {bclk_b, lrck_b, br_b, bf_b, lrr_b, lrf_b, 10'(idx_b)};
                total++;
                if (got_a !== x.a) begin
                    bad++;
                    $display("FAIL gen_default t=%0d got=%b required=%b", x.t, got_a, x.a);
                end
                total++;
                if (got_b !== x.b) begin
                    bad++;
                    $display("FAIL gen_min t=%0d got=%b required=%b", x.t, got_b, x.b);
                end
            end else if (started) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty got=0 entries required=1");
            end
        end
    end

    initial begin
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 2100; i++) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 700; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1);
        // Reset landing exactly on a divider terminal count in both generators.
        while ((t % 8) != 7) step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 1500; i++)
            step(($urandom % 150) == 0, ($urandom % 100) != 0);
        @(posedge clk);
        #2;
        started = 0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_bit_lr_clock_gen.md
# audio_bit_lr_clock_gen

Generates the audio bit clock (BCLK) and left/right clock (LRCK) for the audio codec, plus the single-cycle edge strobes `bit_clk_rising_edge`, `bit_clk_falling_edge`, `left_right_clk_rising_edge` and `left_right_clk_falling_edge` in the `clk` domain. It sits directly upstream of the audio-out serializer and the audio-in deserializer, which consume the strobes. Every LRCK edge coincides with a BCLK falling edge, so left-justified frames start cleanly. LRCK high denotes the left channel.

## Interface
Parameters:
- `BCLK_HALF_PERIOD`, default 8: `clk` cycles per BCLK half period; minimum 2.
- `BITS_PER_CHANNEL`, default 32: BCLK periods per LRCK half period; minimum 2.
- `IDX_W`, default `$clog2(BITS_PER_CHANNEL)`: width of `bit_index`.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `enable`  in  1  run the generator; low gives the same effect as reset on the next edge.
- `bclk`  out  1  bit clock to the codec.
- `lrck`  out  1  left/right clock to the codec; 1 = left.
- `bit_clk_rising_edge`  out  1  one-cycle strobe; asserted in the cycle `bclk` first reads 1.
- `bit_clk_falling_edge`  out  1  one-cycle strobe; asserted in the cycle `bclk` first reads 0.
- `left_right_clk_rising_edge`  out  1  one-cycle strobe on LRCK 0→1.
- `left_right_clk_falling_edge`  out  1  one-cycle strobe on LRCK 1→0.
- `bit_index`  out  `IDX_W`  BCLK falling edges counted since the last LRCK edge.
- `bclk_in`, `lrck_in`  in  1  only present with `AUDIO_CLK_SLAVE_EN`.

## Operation
Reset behaviour:
- Reset, or `enable` = 0, clears all state on the next edge.
- Cleared state: `bclk` = 0, `lrck` = 0, all four strobes = 0, `bit_index` = 0, divider count = 0, falling-edge count = 0.

Master mode (default):
- The divider count runs 0 … `BCLK_HALF_PERIOD`−1.
- At terminal count, the count returns to 0 and `bclk` toggles.
- The matching rising or falling strobe is registered in the same edge as the toggle.
- Each BCLK falling edge increments `bit_index`.
- On the falling edge where `bit_index` = `BITS_PER_CHANNEL`−1:
  - `bit_index` wraps to 0;
  - `lrck` toggles;
  - the LR strobe for the new level is asserted in the same cycle as `bit_clk_falling_edge`.
- Strobes are registered outputs, never combinational. All outputs are registered.
- The LR strobes are always simultaneous with a `bit_clk_falling_edge` strobe. Downstream blocks give the LR strobe priority.

Timing arithmetic:
- BCLK period = 2·`BCLK_HALF_PERIOD` `clk` cycles.
- LRCK period = 4·`BCLK_HALF_PERIOD`·`BITS_PER_CHANNEL` `clk` cycles; 1024 at the defaults, i.e. 48.83 kHz at 50 MHz.
- The `bit_index` width is sized by `IDX_W`.

## Timing
Master mode, counted from edge 1, the first edge with `reset` = 0 and `enable` = 1:
- BCLK:
  - `bclk` rises at edge `BCLK_HALF_PERIOD` (8) and falls at edge 2·`BCLK_HALF_PERIOD` (16).
  - Each strobe is high for exactly one cycle.
- LRCK:
  - First `lrck` rise, with `left_right_clk_rising_edge`, at edge 2·`BCLK_HALF_PERIOD`·`BITS_PER_CHANNEL` (512).
  - First `lrck` fall at edge 1024.
- Strobe spacing: minimum `BCLK_HALF_PERIOD` cycles between any two BCLK strobes. No two BCLK strobes ever share a cycle.
- Mid-frame reset or `enable` drop:
  - All outputs reach their cleared values one edge later.
  - No strobe is emitted for the forced-low transition of `bclk` or `lrck`.
  - Restart begins from edge 1 as above.

## Configuration
`AUDIO_CLK_SLAVE_EN`, not defined (default):
- Master mode as described.
- `bclk_in` and `lrck_in` are absent.

`AUDIO_CLK_SLAVE_EN`, defined (the codec is clock master):
- `bclk_in` and `lrck_in` each pass through a 2-FF synchronizer, then a previous-value register.
- `bclk` and `lrck` mirror the synchronized values.
- Strobes are generated from synchronized ≠ previous value. Latency from pin change to strobe is 3 `clk` edges.
- `bit_index` increments on each falling strobe and clears on each LR strobe.
- `enable` = 0 clears the strobes, `bit_index` and the previous-value registers.
- The divider is not built.
- Constraint: the input BCLK half period must be at least 3 `clk` cycles.

## Test plan
- Reset held 5 cycles, then `enable` = 1 with defaults → `bclk` rises at edge 8, falls at edge 16, period 16; strobes exactly one cycle wide.
- Run 2100 cycles → `lrck` rises at 512, falls at 1024, rises at 1536, falls at 2048; every LR strobe coincides with `bit_clk_falling_edge`; `bit_index` runs 0…31 and wraps.
- Drop `enable` at cycle 700 (mid-left-channel) → next edge `bclk` = `lrck` = 0, `bit_index` = 0, no strobes. Raise `enable` again → first rise 8 cycles later.
- `BCLK_HALF_PERIOD` = 2, `BITS_PER_CHANNEL` = 2 → BCLK period 4; LRCK toggles every 8 cycles; rising and falling strobes alternate without gaps.
- `AUDIO_CLK_SLAVE_EN`, drive `bclk_in` with half period 5 and `lrck_in` toggling every 32 BCLK periods, on a falling edge → each strobe appears 3 edges after its pin change; `bit_index` clears on each LR strobe.
- Assert reset simultaneously with a terminal count → reset wins; outputs cleared; no strobe.
